// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and width-independent constant helpers for muldiv_unit
package muldiv_pkg;
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   function automatic logic [63:0] most_neg(input int xlen);
      return 64'd1 << (xlen - 1);
   endfunction

   function automatic logic [63:0] all_ones(input int xlen);
      return (64'd1 << xlen) - 64'd1;
   endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add or restoring-divide bit per clock
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN  = XLEN'(most_neg(XLEN));
   localparam logic [XLEN-1:0] ONES = XLEN'(all_ones(XLEN));

   state_t state, state_nx;
   logic [2:0] op;
   logic neg;
   logic [XLEN-1:0] b;
   logic [2*XLEN-1:0] acc, acc_nx, prod;
   logic [CW-1:0] cnt;
   logic signed1, signed2, s1, s2, neg_in, special, last, ge;
   logic [XLEN-1:0] m1, m2, special_res, q_fix, r_fix, fix;
   logic [XLEN:0] sum, shifted, diff;

   assign signed1 = i_op != OP_MULHU && i_op != OP_DIVU && i_op != OP_REMU;
   assign signed2 = signed1 && i_op != OP_MULHSU;
   assign s1 = signed1 && i_op1[XLEN-1];
   assign s2 = signed2 && i_op2[XLEN-1];
   assign m1 = s1 ? -i_op1 : i_op1;
   assign m2 = s2 ? -i_op2 : i_op2;
   assign neg_in = i_op == OP_REM ? s1 : s1 ^ s2;
   assign special = i_op[2] && (i_op2 == '0 || (!i_op[0] && i_op1 == MIN && i_op2 == ONES));
   assign special_res = i_op2 == '0 ? (i_op[1] ? i_op1 : ONES) : (i_op[1] ? '0 : MIN);

   // acc holds {product high, multiplier} for multiply, {remainder, dividend/quotient} for divide
   assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
   assign shifted = acc[2*XLEN-1:XLEN-1];
   assign diff = shifted - {1'b0, b};
   assign ge = !diff[XLEN];
   assign acc_nx = op[2] ? {ge ? diff[XLEN-1:0] : shifted[XLEN-1:0], acc[XLEN-2:0], ge}
                         : {sum, acc[XLEN-1:1]};
   assign last = cnt == CW'(XLEN - 1);

   assign prod = neg ? -acc_nx : acc_nx;
   assign q_fix = neg ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
   assign r_fix = neg ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
   assign fix = op[2] ? (op[1] ? r_fix : q_fix)
                      : (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

   assign o_ready = state == IDLE && !i_rst;
   assign o_valid = state == DONE;
   assign o_busy  = state != IDLE;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_valid) state_nx = special ? DONE : CALC;
         CALC:    if (last) state_nx = DONE;
         DONE:    if (i_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state    <= IDLE;
         op       <= '0;
         neg      <= 1'b0;
         b        <= '0;
         acc      <= '0;
         cnt      <= '0;
         o_result <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && i_valid) begin
            op  <= i_op;
            neg <= neg_in;
            b   <= m2;
            acc <= {{XLEN{1'b0}}, m1};
            cnt <= '0;
            if (special) o_result <= special_res;
         end else if (state == CALC) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (last) o_result <= fix;
         end
      end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors with a result scoreboard plus backpressure and reset sequences
module tb_muldiv_unit;
   import muldiv_pkg::*;
   localparam int XLEN = 32;

   logic i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b1;
   logic [2:0] i_op = '0;
   logic [31:0] i_op1 = '0, i_op2 = '0;
   logic o_ready, o_valid, o_busy;
   logic [31:0] o_result;
   int tests = 0, fails = 0;
   logic [31:0] sb[$];

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t vecs[$];

   always #5 i_clk = ~i_clk;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_op1(i_op1), .i_op2(i_op2), .o_valid(o_valid),
      .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!o_valid && n < 200) begin
         @(posedge i_clk); #1;
         n++;
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      @(negedge i_clk);
      i_op = op; i_op1 = a; i_op2 = b; i_valid = 1'b1;
      sb.push_back(exp);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_op1 = $urandom;
      i_op2 = $urandom;
   endtask

   task automatic issue(input vec_t v);
      int n;
      logic [31:0] e;
      @(negedge i_clk);
      check({v.name, " ready"}, 64'(o_ready), 64'd1);
      drive(v.op, v.a, v.b, v.exp);
      wait_valid(n);
      check({v.name, " latency"}, 64'(n), 64'(v.lat));
      e = sb.pop_front();
      check({v.name, " result"}, 64'(o_result), 64'(e));
      check({v.name, " busy"}, 64'(o_busy), 64'd1);
      @(posedge i_clk); #1;
      check({v.name, " handoff"}, 64'({o_valid, o_ready}), 64'd1);
   endtask

   initial begin
      int n;
      int xfers;
      logic seen;
      logic [31:0] e;
      vecs.push_back('{"mul_7_m3",      OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 32});
      vecs.push_back('{"mulh_min",      OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 32});
      vecs.push_back('{"mulhu_ones",    OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32});
      vecs.push_back('{"mulhsu_m1",     OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 32});
      vecs.push_back('{"mulhu_min_2",   OP_MULHU,  32'h80000000,   32'd2,        32'd1,        32});
      vecs.push_back('{"div_m7_2",      OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32});
      vecs.push_back('{"rem_m7_2",      OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32});
      vecs.push_back('{"div_7_m2",      OP_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32});
      vecs.push_back('{"rem_7_m2",      OP_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        32});
      vecs.push_back('{"divu_100_7",    OP_DIVU,   32'd100,        32'd7,        32'd14,       32});
      vecs.push_back('{"remu_100_7",    OP_REMU,   32'd100,        32'd7,        32'd2,        32});
      vecs.push_back('{"divu_5_0",      OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 0});
      vecs.push_back('{"div_5_0",       OP_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 0});
      vecs.push_back('{"rem_5_0",       OP_REM,    32'd5,          32'd0,        32'd5,        0});
      vecs.push_back('{"div_ovf",       OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0});
      vecs.push_back('{"rem_ovf",       OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        0});

      repeat (2) @(posedge i_clk);
      #1;
      check("rst ready", 64'(o_ready), 64'd0);
      check("rst valid", 64'(o_valid), 64'd0);
      check("rst busy", 64'(o_busy), 64'd0);
      check("rst result", 64'(o_result), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check("post rst ready", 64'(o_ready), 64'd1);

      foreach (vecs[i]) issue(vecs[i]);

      // backpressure: result held for 10 cycles while new requests are offered
      i_ready = 1'b0;
      drive(OP_DIVU, 32'd100, 32'd7, 32'd14);
      wait_valid(n);
      check("bp latency", 64'(n), 64'd32);
      e = sb.pop_front();
      xfers = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clk);
         i_valid = c[0];
         i_op = OP_MUL; i_op1 = 32'd9; i_op2 = 32'd9;
         check("bp result", 64'(o_result), 64'(e));
         check("bp ready", 64'(o_ready), 64'd0);
         check("bp valid", 64'(o_valid), 64'd1);
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      if (o_valid && i_ready) xfers++;
      @(posedge i_clk); #1;
      for (int c = 0; c < 5; c++) begin
         if (o_valid) xfers++;
         @(posedge i_clk); #1;
      end
      check("bp transfers", 64'(xfers), 64'd1);
      check("bp idle", 64'({o_busy, o_ready}), 64'd1);

      // reset in the middle of a divide
      drive(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
      repeat (14) @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      sb.delete();
      #1;
      check("abort valid", 64'(o_valid), 64'd0);
      check("abort busy", 64'(o_busy), 64'd0);
      check("abort ready", 64'(o_ready), 64'd0);
      check("abort result", 64'(o_result), 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check("abort idle", 64'(o_ready), 64'd1);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge i_clk); #1;
         if (o_valid) seen = 1'b1;
      end
      check("abort no result", 64'(seen), 64'd0);
      issue('{"mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, 32});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
